nx_msg_distributor: RTL and testbench
=====================================

NX_MSG_DISTRIBUTOR -- requirements
Module: nx_msg_distributor

Interface
REQ-001 SHALL have parameter STREAM_WIDTH, default 32, width of every message stream.
REQ-002 SHALL have parameter ADDR_ROW_WIDTH, default 4, width of the target-row field.
REQ-003 SHALL have parameter ADDR_COL_WIDTH, default 4, width of the target-column field.
REQ-004 SHALL have port clk_i, input, 1, the single clock.
REQ-005 SHALL have port rst_i, input, 1, the reset, asynchronous and active-low.
REQ-006 SHALL have ports node_row_i / node_col_i, input, ADDR_ROW_WIDTH / ADDR_COL_WIDTH, this node's position, static after reset.
REQ-007 SHALL have ports msg_data_i (STREAM_WIDTH), msg_dir_i (2), msg_valid_i (1) as inputs and msg_ready_o (1) as output, the arbitrated inbound stream from nx_stream_arbiter.
REQ-008 SHALL have, for each of north, east, south and west, ports <dir>_data_o (STREAM_WIDTH), <dir>_valid_o (1) as outputs and <dir>_ready_i (1) as input, the outbound mesh streams.
REQ-009 SHALL have ports int_data_o (STREAM_WIDTH), int_dir_o (2), int_valid_o (1) as outputs and int_ready_i (1) as input, the stream to the local node.
REQ-010 SHALL have port int_count_o, output, 16, the number of messages delivered to the local node.

Function
REQ-011 SHALL take the target row from msg_data_i[STREAM_WIDTH-1 -: ADDR_ROW_WIDTH] and the target column from the next ADDR_COL_WIDTH bits below it.
REQ-012 SHALL route by unsigned compare, row first: target row < node row -> north; target row > node row -> south; rows equal and target column < node column -> west; rows equal and target column > node column -> east; both equal -> internal.
REQ-013 SHALL give each of the five output ports its own 2-entry FIFO; a port's data and valid outputs are driven only from the head of its FIFO.
REQ-014 SHALL drive msg_ready_o high exactly when the FIFO of the currently decoded target port is not full; this is combinational from msg_data_i and FIFO occupancy.
REQ-015 SHALL accept an inbound message on a cycle with msg_valid_i && msg_ready_o, and push it unmodified into exactly one FIFO.
REQ-016 SHALL present an accepted message on its output port in the cycle after acceptance if that FIFO was empty (1-cycle latency).
REQ-017 SHALL store msg_dir_i alongside each internal-port entry and present it on int_dir_o.
REQ-018 SHALL pop a FIFO on <port>_valid_o && <port>_ready_i.
REQ-019 SHALL support a push and a pop on the same FIFO in the same cycle, including when the FIFO is full; occupancy is then unchanged and ordering is preserved.
REQ-020 SHALL never let a full FIFO for one port stall acceptance of messages for other ports, except through head-of-line blocking at the input.
REQ-021 SHALL hold <port>_data_o stable while <port>_valid_o is high and <port>_ready_i is low.
REQ-022 SHALL increment int_count_o on each internal-port pop, saturating at 16'hFFFF.

Reset
REQ-023 SHALL, while rst_i is low, clear all FIFO occupancies, drive all *_valid_o low, all *_data_o and int_dir_o to 0, and int_count_o to 0.
REQ-024 SHALL discard any in-flight FIFO contents when rst_i is asserted mid-operation; no message is emitted after reset release unless it is accepted again.
REQ-025 SHALL drive msg_ready_o high in the first cycle after reset release, since all FIFOs are empty.

Structure
REQ-026 SHALL take the direction constants (DIRX_NORTH/EAST/SOUTH/WEST) and the header field positions from the shared nx_constants include/package; no local redefinitions.
REQ-027 SHALL implement the per-port buffering as one sub-module, nx_msg_fifo (parameters WIDTH, DEPTH=2), instantiated five times.

Verification
REQ-028 SHALL cover local delivery: node (2,3), inbound 0x23xxxxxx with dir=1 -> int_valid_o the next cycle, int_dir_o=1, int_count_o=1 after the pop.
REQ-029 SHALL cover routing: node (2,3) with headers 0x1…, 0x3…, 0x21…, 0x25… -> the messages appear on north, south, west and east respectively, with data unmodified.
REQ-030 SHALL cover backpressure: east_ready_i=0, three east-bound messages -> two accepted, msg_ready_o low on the third, and no other port blocked once that message is replaced by a north-bound one.
REQ-031 SHALL cover simultaneous push and pop on a full north FIFO -> occupancy stays at 2 and output order is A, B, C.
REQ-032 SHALL cover saturation: int_count_o preloaded to 16'hFFFE, then three internal pops -> the count reads 16'hFFFF.
REQ-033 SHALL cover mid-stream reset: rst_i low for 1 cycle with FIFOs non-empty -> all valid outputs drop immediately, stay 0 afterwards, and int_count_o=0.

Source files
------------

// File: rtl/nx_constants_pkg.sv
// nx_constants_pkg
//   Shared mesh constants for the nx message fabric.
//   - DIRX_* : 2-bit direction codes carried on msg_dir_i / int_dir_o.
//   - port_e : output port selector used by the distributor. The four mesh
//              ports reuse the DIRX codes so a port and its direction agree.
//   - hdr_row_msb / hdr_col_msb : bit positions of the target-row and
//              target-column fields at the top of a message word.
package nx_constants_pkg;

  localparam logic [1:0] DIRX_NORTH = 2'd0;
  localparam logic [1:0] DIRX_EAST  = 2'd1;
  localparam logic [1:0] DIRX_SOUTH = 2'd2;
  localparam logic [1:0] DIRX_WEST  = 2'd3;

  localparam int NUM_OUT_PORTS = 5;

  typedef enum logic [2:0] {
    PORT_NORTH = {1'b0, DIRX_NORTH},
    PORT_EAST  = {1'b0, DIRX_EAST},
    PORT_SOUTH = {1'b0, DIRX_SOUTH},
    PORT_WEST  = {1'b0, DIRX_WEST},
    PORT_INT   = 3'd4
  } port_e;

  // The target row occupies the most significant bits of the message.
  function automatic int hdr_row_msb(input int stream_width);
    return stream_width - 1;
  endfunction

  // The target column sits directly below the target row.
  function automatic int hdr_col_msb(input int stream_width, input int row_width);
    return stream_width - 1 - row_width;
  endfunction

endpackage

// File: rtl/nx_msg_fifo.sv
// nx_msg_fifo
//   Small synchronous FIFO feeding one outbound port of the distributor.
//   The port's data/valid are taken straight from the FIFO head, so the
//   head word stays put until it is popped.
//   Parameters: WIDTH (entry width), DEPTH (entries, default 2)
//   Ports:
//     clk_i, rst_i   clock, asynchronous active-low reset
//     push_i, data_i write request and word
//     full_o         no free entry (a push is still taken if a pop coincides)
//     pop_i          consume the head word (ignored while empty)
//     data_o         head word
//     valid_o        FIFO holds at least one word
module nx_msg_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             full_o,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_o  = (count == CNT_W'(DEPTH));
  assign valid_o = (count != '0);
  assign data_o  = mem[rd_ptr];

  // A pop frees the head slot in the same cycle, so a push into a full
  // FIFO is fine as long as it pairs with a pop.
  assign do_pop  = pop_i && valid_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Storage and pointers; clearing the memory keeps data_o at zero in reset.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= data_i;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/nx_msg_distributor.sv
// nx_msg_distributor
//   Routes the arbitrated inbound message stream of a mesh node to one of
//   four neighbour links or to the local node, using dimension-ordered
//   (row first) routing on the target address in the message header.
//   Every output has its own 2-entry FIFO; the inbound stream is stalled
//   only when the FIFO of the message's own destination is full.
//   Parameters: STREAM_WIDTH, ADDR_ROW_WIDTH, ADDR_COL_WIDTH
//   Ports:
//     clk_i, rst_i                    clock, asynchronous active-low reset
//     node_row_i, node_col_i          this node's mesh position
//     msg_data_i/dir_i/valid_i/ready_o inbound stream
//     <dir>_data_o/valid_o/ready_i    outbound north/east/south/west links
//     int_data_o/dir_o/valid_o/ready_i local delivery stream (with the
//                                     direction the message arrived from)
//     int_count_o                     saturating count of local deliveries
module nx_msg_distributor
  import nx_constants_pkg::*;
#(
  parameter int STREAM_WIDTH   = 32,
  parameter int ADDR_ROW_WIDTH = 4,
  parameter int ADDR_COL_WIDTH = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [ADDR_ROW_WIDTH-1:0] node_row_i,
  input  logic [ADDR_COL_WIDTH-1:0] node_col_i,

  input  logic [STREAM_WIDTH-1:0]   msg_data_i,
  input  logic [1:0]                msg_dir_i,
  input  logic                      msg_valid_i,
  output logic                      msg_ready_o,

  output logic [STREAM_WIDTH-1:0]   north_data_o,
  output logic                      north_valid_o,
  input  logic                      north_ready_i,

  output logic [STREAM_WIDTH-1:0]   east_data_o,
  output logic                      east_valid_o,
  input  logic                      east_ready_i,

  output logic [STREAM_WIDTH-1:0]   south_data_o,
  output logic                      south_valid_o,
  input  logic                      south_ready_i,

  output logic [STREAM_WIDTH-1:0]   west_data_o,
  output logic                      west_valid_o,
  input  logic                      west_ready_i,

  output logic [STREAM_WIDTH-1:0]   int_data_o,
  output logic [1:0]                int_dir_o,
  output logic                      int_valid_o,
  input  logic                      int_ready_i,

  output logic [15:0]               int_count_o
);

  localparam int ROW_MSB = hdr_row_msb(STREAM_WIDTH);
  localparam int COL_MSB = hdr_col_msb(STREAM_WIDTH, ADDR_ROW_WIDTH);

  logic [ADDR_ROW_WIDTH-1:0] tgt_row;
  logic [ADDR_COL_WIDTH-1:0] tgt_col;
  port_e                     tgt_port;
  logic                      accept;

  logic north_full, east_full, south_full, west_full, int_full;
  logic north_push, east_push, south_push, west_push, int_push;

  logic [STREAM_WIDTH+1:0]   int_entry;
  logic [15:0]               int_count_q;

  assign tgt_row = msg_data_i[ROW_MSB -: ADDR_ROW_WIDTH];
  assign tgt_col = msg_data_i[COL_MSB -: ADDR_COL_WIDTH];

  // Row first: a message only moves east/west once it is in the right row.
  always_comb begin
    tgt_port = PORT_INT;
    if (tgt_row < node_row_i) begin
      tgt_port = PORT_NORTH;
    end else if (tgt_row > node_row_i) begin
      tgt_port = PORT_SOUTH;
    end else if (tgt_col < node_col_i) begin
      tgt_port = PORT_WEST;
    end else if (tgt_col > node_col_i) begin
      tgt_port = PORT_EAST;
    end
  end

  // Ready reflects only the decoded destination, so a full FIFO elsewhere
  // never holds up this message.
  always_comb begin
    msg_ready_o = 1'b0;
    case (tgt_port)
      PORT_NORTH: msg_ready_o = !north_full;
      PORT_EAST:  msg_ready_o = !east_full;
      PORT_SOUTH: msg_ready_o = !south_full;
      PORT_WEST:  msg_ready_o = !west_full;
      PORT_INT:   msg_ready_o = !int_full;
      default:    msg_ready_o = 1'b0;
    endcase
  end

  assign accept     = msg_valid_i && msg_ready_o;
  assign north_push = accept && (tgt_port == PORT_NORTH);
  assign east_push  = accept && (tgt_port == PORT_EAST);
  assign south_push = accept && (tgt_port == PORT_SOUTH);
  assign west_push  = accept && (tgt_port == PORT_WEST);
  assign int_push   = accept && (tgt_port == PORT_INT);

  nx_msg_fifo #(.WIDTH(STREAM_WIDTH), .DEPTH(2)) u_north_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (north_push),
    .data_i  (msg_data_i),
    .full_o  (north_full),
    .pop_i   (north_ready_i),
    .data_o  (north_data_o),
    .valid_o (north_valid_o)
  );

  nx_msg_fifo #(.WIDTH(STREAM_WIDTH), .DEPTH(2)) u_east_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (east_push),
    .data_i  (msg_data_i),
    .full_o  (east_full),
    .pop_i   (east_ready_i),
    .data_o  (east_data_o),
    .valid_o (east_valid_o)
  );

  nx_msg_fifo #(.WIDTH(STREAM_WIDTH), .DEPTH(2)) u_south_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (south_push),
    .data_i  (msg_data_i),
    .full_o  (south_full),
    .pop_i   (south_ready_i),
    .data_o  (south_data_o),
    .valid_o (south_valid_o)
  );

  nx_msg_fifo #(.WIDTH(STREAM_WIDTH), .DEPTH(2)) u_west_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (west_push),
    .data_i  (msg_data_i),
    .full_o  (west_full),
    .pop_i   (west_ready_i),
    .data_o  (west_data_o),
    .valid_o (west_valid_o)
  );

  // The local FIFO also keeps the arrival direction next to the message.
  nx_msg_fifo #(.WIDTH(STREAM_WIDTH + 2), .DEPTH(2)) u_int_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (int_push),
    .data_i  ({msg_dir_i, msg_data_i}),
    .full_o  (int_full),
    .pop_i   (int_ready_i),
    .data_o  (int_entry),
    .valid_o (int_valid_o)
  );

  assign int_dir_o  = int_entry[STREAM_WIDTH+1 -: 2];
  assign int_data_o = int_entry[STREAM_WIDTH-1:0];

  // Local delivery counter, sticking at all-ones instead of wrapping.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      int_count_q <= '0;
    end else if (int_valid_o && int_ready_i && (int_count_q != 16'hFFFF)) begin
      int_count_q <= int_count_q + 16'd1;
    end
  end

  assign int_count_o = int_count_q;

endmodule

// File: tb/tb_nx_msg_distributor.sv
// tb_nx_msg_distributor
//   Drives nx_msg_distributor (node at row 2, column 3) with directed and
//   random traffic and compares every output against a queue-based model
//   of where each message should end up.
module tb_nx_msg_distributor;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [3:0]  node_row_i;
  logic [3:0]  node_col_i;
  logic [31:0] msg_data_i;
  logic [1:0]  msg_dir_i;
  logic        msg_valid_i;
  logic        msg_ready_o;
  logic [31:0] north_data_o, east_data_o, south_data_o, west_data_o, int_data_o;
  logic        north_valid_o, east_valid_o, south_valid_o, west_valid_o, int_valid_o;
  logic        north_ready_i, east_ready_i, south_ready_i, west_ready_i, int_ready_i;
  logic [1:0]  int_dir_o;
  logic [15:0] int_count_o;

  always #5 clk_i = ~clk_i;

  nx_msg_distributor #(
    .STREAM_WIDTH(32), .ADDR_ROW_WIDTH(4), .ADDR_COL_WIDTH(4)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .node_row_i(node_row_i), .node_col_i(node_col_i),
    .msg_data_i(msg_data_i), .msg_dir_i(msg_dir_i),
    .msg_valid_i(msg_valid_i), .msg_ready_o(msg_ready_o),
    .north_data_o(north_data_o), .north_valid_o(north_valid_o), .north_ready_i(north_ready_i),
    .east_data_o(east_data_o), .east_valid_o(east_valid_o), .east_ready_i(east_ready_i),
    .south_data_o(south_data_o), .south_valid_o(south_valid_o), .south_ready_i(south_ready_i),
    .west_data_o(west_data_o), .west_valid_o(west_valid_o), .west_ready_i(west_ready_i),
    .int_data_o(int_data_o), .int_dir_o(int_dir_o), .int_valid_o(int_valid_o),
    .int_ready_i(int_ready_i), .int_count_o(int_count_o)
  );

  // Port order everywhere in the bench: 0 north, 1 east, 2 south, 3 west, 4 local.
  logic [4:0]  out_valid;
  logic [33:0] out_data [5];
  assign out_valid   = {int_valid_o, west_valid_o, south_valid_o, east_valid_o, north_valid_o};
  assign out_data[0] = {2'b00, north_data_o};
  assign out_data[1] = {2'b00, east_data_o};
  assign out_data[2] = {2'b00, south_data_o};
  assign out_data[3] = {2'b00, west_data_o};
  assign out_data[4] = {int_dir_o, int_data_o};

  // Reference model: what each port still owes, and how many local pops happened.
  logic [33:0] mq [5][$];
  int          local_pops;
  int          vectors;
  int          miscompares;
  logic [4:0]  cur_rdy;

  localparam logic [4:0] ALL_READY = 5'b11111;

  function automatic int route(input logic [31:0] d);
    int row;
    int col;
    row = int'(d[31:28]);
    col = int'(d[27:24]);
    if (row < 2) return 0;
    if (row > 2) return 2;
    if (col < 3) return 3;
    if (col > 3) return 1;
    return 4;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  task automatic checkAll();
    int expCount;
    expCount = (local_pops > 65535) ? 65535 : local_pops;
    checkOutput("msg_ready", 64'(msg_ready_o), 64'(mq[route(msg_data_i)].size() < 2));
    for (int p = 0; p < 5; p++) begin
      checkOutput($sformatf("valid[%0d]", p), 64'(out_valid[p]), 64'(mq[p].size() != 0));
      if (mq[p].size() != 0) begin
        checkOutput($sformatf("data[%0d]", p), 64'(out_data[p]), 64'(mq[p][0]));
      end else if (!rst_i) begin
        checkOutput($sformatf("rst_data[%0d]", p), 64'(out_data[p]), 64'd0);
      end
    end
    checkOutput("int_count", 64'(int_count_o), 64'(expCount));
  endtask

  task automatic updateModel();
    bit accepted;
    int dst;
    dst      = route(msg_data_i);
    accepted = msg_valid_i && (mq[dst].size() < 2);
    for (int p = 0; p < 5; p++) begin
      if (mq[p].size() != 0 && cur_rdy[p]) begin
        void'(mq[p].pop_front());
        if (p == 4) local_pops++;
      end
    end
    if (accepted) begin
      mq[dst].push_back((dst == 4) ? {msg_dir_i, msg_data_i} : {2'b00, msg_data_i});
    end
  endtask

  // One clock cycle: drive after the edge, check mid-cycle, advance the model on the edge.
  task automatic applyStimulus(input logic rstn, input logic valid, input logic [31:0] data,
                               input logic [1:0] dir, input logic [4:0] rdy);
    rst_i         = rstn;
    msg_valid_i   = valid;
    msg_data_i    = data;
    msg_dir_i     = dir;
    cur_rdy       = rdy;
    north_ready_i = rdy[0];
    east_ready_i  = rdy[1];
    south_ready_i = rdy[2];
    west_ready_i  = rdy[3];
    int_ready_i   = rdy[4];
    if (!rstn) begin
      for (int p = 0; p < 5; p++) mq[p].delete();
      local_pops = 0;
    end
    @(negedge clk_i);
    checkAll();
    @(posedge clk_i);
    if (rstn) updateModel();
    #1;
  endtask

  task automatic idle(input int n, input logic [4:0] rdy);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 32'h2300_0000, 2'd0, rdy);
  endtask

  function automatic logic [31:0] randomHeader();
    logic [3:0] row;
    logic [3:0] col;
    row = 4'($urandom_range(1, 3));
    col = 4'($urandom_range(2, 4));
    return {row, col, 24'($urandom)};
  endfunction

  initial begin
    vectors     = 0;
    miscompares = 0;
    local_pops  = 0;
    node_row_i  = 4'd2;
    node_col_i  = 4'd3;

    // Reset, then release: everything empty and the input ready.
    applyStimulus(1'b0, 1'b0, 32'h0, 2'd0, ALL_READY);
    applyStimulus(1'b0, 1'b0, 32'h0, 2'd0, ALL_READY);
    idle(2, ALL_READY);

    // Local delivery with arrival direction 1.
    applyStimulus(1'b1, 1'b1, 32'h23AB_CD01, 2'd1, ALL_READY);
    idle(2, ALL_READY);

    // One message to each neighbour.
    applyStimulus(1'b1, 1'b1, 32'h1000_00AA, 2'd0, ALL_READY);
    applyStimulus(1'b1, 1'b1, 32'h3000_00BB, 2'd0, ALL_READY);
    applyStimulus(1'b1, 1'b1, 32'h2100_00CC, 2'd0, ALL_READY);
    applyStimulus(1'b1, 1'b1, 32'h2500_00DD, 2'd0, ALL_READY);
    idle(2, ALL_READY);

    // East stalled: third east message refused, north traffic still flows.
    applyStimulus(1'b1, 1'b1, 32'h2500_0001, 2'd2, 5'b11101);
    applyStimulus(1'b1, 1'b1, 32'h2500_0002, 2'd2, 5'b11101);
    applyStimulus(1'b1, 1'b1, 32'h2500_0003, 2'd2, 5'b11101);
    applyStimulus(1'b1, 1'b1, 32'h2500_0003, 2'd2, 5'b11101);
    applyStimulus(1'b1, 1'b1, 32'h1000_0004, 2'd2, 5'b11101);
    idle(3, ALL_READY);

    // Full north FIFO drained while C is offered: order must be A, B, C.
    applyStimulus(1'b1, 1'b1, 32'h1000_000A, 2'd1, 5'b11110);
    applyStimulus(1'b1, 1'b1, 32'h1000_000B, 2'd1, 5'b11110);
    applyStimulus(1'b1, 1'b1, 32'h1000_000C, 2'd1, 5'b11110);
    applyStimulus(1'b1, 1'b1, 32'h1000_000C, 2'd1, ALL_READY);
    applyStimulus(1'b1, 1'b1, 32'h1000_000C, 2'd1, ALL_READY);
    idle(3, ALL_READY);

    // Random traffic and backpressure with occasional resets.
    for (int i = 0; i < 3000 && miscompares < 100; i++) begin
      logic [4:0] rdy;
      for (int p = 0; p < 5; p++) rdy[p] = ($urandom_range(0, 9) < 7);
      applyStimulus(($urandom_range(0, 149) != 0), 1'($urandom), randomHeader(),
                    2'($urandom_range(0, 3)), rdy);
    end
    idle(3, ALL_READY);

    // Stream local messages until the delivery counter has saturated.
    for (int i = 0; i < 70000 && local_pops < 65538 && miscompares < 100; i++) begin
      applyStimulus(1'b1, 1'b1, {8'h23, 24'($urandom)}, 2'($urandom_range(0, 3)), ALL_READY);
    end
    idle(3, ALL_READY);
    checkOutput("count_saturated", 64'(int_count_o), 64'hFFFF);

    // Fill several FIFOs, then reset mid-stream for one cycle.
    applyStimulus(1'b1, 1'b1, 32'h1000_0111, 2'd0, 5'b00000);
    applyStimulus(1'b1, 1'b1, 32'h3000_0222, 2'd0, 5'b00000);
    applyStimulus(1'b1, 1'b1, 32'h2300_0333, 2'd3, 5'b00000);
    applyStimulus(1'b1, 1'b1, 32'h2100_0444, 2'd0, 5'b00000);
    applyStimulus(1'b0, 1'b0, 32'h0, 2'd0, 5'b00000);
    idle(4, 5'b00000);
    idle(2, ALL_READY);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
